// File: rtl/keypad_digit_loader.sv
// keypad_digit_loader: debounces keypad codes and shifts accepted digits
// into a three-digit BCD cook-time entry (M:ST S), calculator style.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-high reset
//   D[3:0]       - key code from encoder (0..9 digits, 10..15 ignored)
//   valid        - encoder valid, one key pressed
//   enable       - entry allowed; gates new presses only
//   clear        - synchronous clear of the entered time
//   minutes      - BCD minutes digit
//   sec_tens     - BCD tens-of-seconds digit
//   sec_ones     - BCD ones-of-seconds digit
//   key_ack      - one-cycle pulse when a new key is shifted in
//   time_nonzero - high when any digit is nonzero
module keypad_digit_loader #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] D,
   input  logic       valid,
   input  logic       enable,
   input  logic       clear,
   output logic [3:0] minutes,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       key_ack,
   output logic       time_nonzero
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   localparam logic [7:0] LP_LAST = 8'(DEBOUNCE_CYCLES - 1);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [3:0] r_cand;

   logic       w_digit;
   logic       w_stable;
   logic       w_last;
   logic       w_accept;
   logic [3:0] w_min_n;
   logic [3:0] w_tens_n;
   logic [3:0] w_ones_n;

   assign w_digit  = (D <= 4'd9);
   assign w_stable = valid & enable & (D == r_cand);
   assign w_last   = (r_cnt == LP_LAST);
   // clear wins over an acceptance landing on the same edge
   assign w_accept = (r_state == PRESS_WAIT) & w_stable
                   & w_last & ~clear;

   // Next digit values; time_nonzero is derived from these so it
   // changes on the same edge as the digits.
   always_comb begin
      w_min_n  = minutes;
      w_tens_n = sec_tens;
      w_ones_n = sec_ones;
      if (clear) begin
         w_min_n  = 4'd0;
         w_tens_n = 4'd0;
         w_ones_n = 4'd0;
      end else if (w_accept) begin
         w_min_n  = sec_tens;
         w_tens_n = sec_ones;
         w_ones_n = r_cand;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cnt        <= 8'd0;
         r_cand       <= 4'd0;
         minutes      <= 4'd0;
         sec_tens     <= 4'd0;
         sec_ones     <= 4'd0;
         key_ack      <= 1'b0;
         time_nonzero <= 1'b0;
      end else begin
         minutes      <= w_min_n;
         sec_tens     <= w_tens_n;
         sec_ones     <= w_ones_n;
         key_ack      <= w_accept;
         time_nonzero <= |{w_min_n, w_tens_n, w_ones_n};
         if (clear) begin
            // A key held across clear must be released first
            if (r_state == HELD || r_state == RELEASE_WAIT) begin
               r_state <= RELEASE_WAIT;
               r_cnt   <= 8'd1;
            end else begin
               r_state <= IDLE;
            end
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (enable & valid & w_digit) begin
                     r_cand  <= D;
                     r_cnt   <= 8'd1;
                     r_state <= PRESS_WAIT;
                  end
               end
               PRESS_WAIT: begin
                  if (!w_stable) begin
                     r_state <= IDLE;
                  end else if (w_last) begin
                     r_state <= HELD;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               HELD: begin
                  if (!valid) begin
                     r_cnt   <= 8'd1;
                     r_state <= RELEASE_WAIT;
                  end
               end
               RELEASE_WAIT: begin
                  if (valid) begin
                     r_state <= HELD;
                  end else if (w_last) begin
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_digit_loader.sv
// tb_keypad_digit_loader: directed vectors for keypad_digit_loader
// with DEBOUNCE_CYCLES = 4.
module tb_keypad_digit_loader;

   logic       clk;
   logic       reset;
   logic [3:0] D;
   logic       valid;
   logic       enable;
   logic       clear;
   logic [3:0] minutes;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       key_ack;
   logic       time_nonzero;

   int errors = 0;
   int checks = 0;

   keypad_digit_loader #(.DEBOUNCE_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .D            (D),
      .valid        (valid),
      .enable       (enable),
      .clear        (clear),
      .minutes      (minutes),
      .sec_tens     (sec_tens),
      .sec_ones     (sec_ones),
      .key_ack      (key_ack),
      .time_nonzero (time_nonzero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      int         n;
      logic       v;
      logic [3:0] d;
      logic       en;
      logic       clr;
      logic [3:0] em;
      logic [3:0] et;
      logic [3:0] eo;
      int         eack;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive inputs for n cycles, count key_ack pulses, then compare
   task automatic run(input vec_t t);
      int acks;
      acks   = 0;
      valid  = t.v;
      D      = t.d;
      enable = t.en;
      clear  = t.clr;
      for (int i = 0; i < t.n; i++) begin
         @(posedge clk);
         #1;
         if (key_ack === 1'b1) acks++;
      end
      check({t.name, " digits"}, {minutes, sec_tens, sec_ones},
            {t.em, t.et, t.eo});
      check({t.name, " acks"}, acks, t.eack);
      check({t.name, " nonzero"}, time_nonzero,
            int'((t.em | t.et | t.eo) != 4'd0));
   endtask

   task automatic rv(input string nm, input int n, input logic v,
                     input logic [3:0] d, input logic clr,
                     input logic [3:0] em, input logic [3:0] et,
                     input logic [3:0] eo, input int eack);
      vec_t t;
      t = '{nm, n, v, d, 1'b1, clr, em, et, eo, eack};
      run(t);
   endtask

   task automatic zero_check(input string nm);
      check({nm, " digits"}, {minutes, sec_tens, sec_ones}, 0);
      check({nm, " ack"}, key_ack, 0);
      check({nm, " nonzero"}, time_nonzero, 0);
   endtask

   vec_t tbl[$];

   initial begin
      reset  = 1'b1;
      D      = 4'd0;
      valid  = 1'b0;
      enable = 1'b1;
      clear  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      zero_check("reset");
      reset = 1'b0;

      // Key 3 held 10 cycles: ack exactly on the 4th edge
      valid = 1'b1;
      D     = 4'd3;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("k3 ack e%0d", i), key_ack, int'(i == 4));
         if (i == 3) check("k3 ones e3", sec_ones, 0);
         if (i == 4) check("k3 ones e4", sec_ones, 3);
      end
      check("k3 nz", time_nonzero, 1);
      check("k3 upper", {minutes, sec_tens}, 0);
      rv("k3 rel", 6, 0, 0, 0, 0, 0, 3, 0);

      // name n v d en clr em et eo acks
      tbl.push_back('{"clr0",  1, 0, 0, 1, 1, 0, 0, 0, 0});
      tbl.push_back('{"k1",    6, 1, 1, 1, 0, 0, 0, 1, 1});
      tbl.push_back('{"r1",    6, 0, 1, 1, 0, 0, 0, 1, 0});
      tbl.push_back('{"k3",    6, 1, 3, 1, 0, 0, 1, 3, 1});
      tbl.push_back('{"r3",    6, 0, 3, 1, 0, 0, 1, 3, 0});
      tbl.push_back('{"k0",    6, 1, 0, 1, 0, 1, 3, 0, 1});
      tbl.push_back('{"r0",    6, 0, 0, 1, 0, 1, 3, 0, 0});
      tbl.push_back('{"k5",    6, 1, 5, 1, 0, 3, 0, 5, 1});
      tbl.push_back('{"r5",    6, 0, 5, 1, 0, 3, 0, 5, 0});
      tbl.push_back('{"k12",  10, 1, 12, 1, 0, 3, 0, 5, 0});
      tbl.push_back('{"r12",   6, 0, 0, 1, 0, 3, 0, 5, 0});
      tbl.push_back('{"dis8", 10, 1, 8, 0, 0, 3, 0, 5, 0});
      tbl.push_back('{"rdis",  6, 0, 8, 1, 0, 3, 0, 5, 0});
      tbl.push_back('{"gl2",   2, 1, 6, 1, 0, 3, 0, 5, 0});
      tbl.push_back('{"gl0",   1, 0, 6, 1, 0, 3, 0, 5, 0});
      tbl.push_back('{"d4",    2, 1, 4, 1, 0, 3, 0, 5, 0});
      tbl.push_back('{"d7",    7, 1, 7, 1, 0, 0, 5, 7, 1});
      tbl.push_back('{"bnc0",  3, 0, 7, 1, 0, 0, 5, 7, 0});
      tbl.push_back('{"bnc1",  1, 1, 9, 1, 0, 0, 5, 7, 0});
      tbl.push_back('{"rbnc",  6, 0, 9, 1, 0, 0, 5, 7, 0});
      tbl.push_back('{"k2",    5, 1, 2, 1, 0, 5, 7, 2, 1});
      tbl.push_back('{"r2",    6, 0, 2, 1, 0, 5, 7, 2, 0});
      foreach (tbl[i]) run(tbl[i]);

      // clear on the accepting edge
      rv("pre6", 3, 1, 6, 0, 5, 7, 2, 0);
      rv("clr6", 1, 1, 6, 1, 0, 0, 0, 0);
      rv("rclr", 6, 0, 6, 0, 0, 0, 0, 0);

      // key held through clear must be re-pressed
      rv("k4",   6, 1, 4, 0, 0, 0, 4, 1);
      rv("clrH", 1, 1, 4, 1, 0, 0, 0, 0);
      rv("hold", 10, 1, 4, 0, 0, 0, 0, 0);
      rv("rel4", 6, 0, 4, 0, 0, 0, 0, 0);
      rv("k4b",  5, 1, 4, 0, 0, 0, 4, 1);
      rv("r4b",  6, 0, 4, 0, 0, 0, 4, 0);

      // reset during PRESS_WAIT with digits 2:4 5
      rv("c",   1, 0, 0, 1, 0, 0, 0, 0);
      rv("a2",  5, 1, 2, 0, 0, 0, 2, 1);
      rv("b2",  6, 0, 2, 0, 0, 0, 2, 0);
      rv("a4",  5, 1, 4, 0, 0, 2, 4, 1);
      rv("b4",  6, 0, 4, 0, 0, 2, 4, 0);
      rv("a5",  5, 1, 5, 0, 2, 4, 5, 1);
      rv("b5",  6, 0, 5, 0, 2, 4, 5, 0);
      rv("pw7", 2, 1, 7, 0, 2, 4, 5, 0);
      #2;
      reset = 1'b1;
      #1;
      zero_check("rstPW");
      valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      rv("postPW", 2, 0, 0, 0, 0, 0, 0, 0);

      // reset during HELD with digits 2:4 5
      rv("h2",  5, 1, 2, 0, 0, 0, 2, 1);
      rv("g2",  6, 0, 2, 0, 0, 0, 2, 0);
      rv("h4",  5, 1, 4, 0, 0, 2, 4, 1);
      rv("g4",  6, 0, 4, 0, 0, 2, 4, 0);
      rv("h5",  6, 1, 5, 0, 2, 4, 5, 1);
      #2;
      reset = 1'b1;
      #1;
      zero_check("rstH");
      valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      rv("postH", 6, 0, 0, 0, 0, 0, 0, 0);
      rv("k9",    5, 1, 9, 0, 0, 0, 9, 1);
      rv("r9",    6, 0, 9, 0, 0, 0, 9, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keypad_digit_loader.md
# keypad_digit_loader

Consumes the `D`/`valid` code stream from the keypad priority encoder and builds the microwave cook-time entry as three BCD digits (M:ST S), shifting each new key in from the right like a calculator display. It debounces press and release so that one physical keypress produces exactly one shift. It sits between the keypad encoder and the cook-timer and display logic, and holds the entered time until cleared.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive clock samples required to accept a press and to confirm a release; legal range 2..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `D`  in  4  key code from the encoder; 0..9 are digits, 10..15 are ignored.
- `valid`  in  1  encoder valid; high while exactly one key is pressed.
- `enable`  in  1  entry allowed (door closed, not cooking); gates new presses only.
- `clear`  in  1  synchronous clear of the entered time.
- `minutes`  out  4  BCD minutes digit.
- `sec_tens`  out  4  BCD tens-of-seconds digit.
- `sec_ones`  out  4  BCD ones-of-seconds digit.
- `key_ack`  out  1  one-cycle pulse, high in the cycle the digits show a newly shifted key.
- `time_nonzero`  out  1  high when any digit is nonzero (registered).

## Operation
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. There is an internal 8-bit counter `cnt` and a 4-bit candidate register `cand`.
- IDLE: if `enable & valid & D<=9`, latch `cand<=D`, set `cnt<=1`, and go to PRESS_WAIT. Otherwise stay in IDLE.
- PRESS_WAIT:
  - If `!valid`, `!enable`, or `D!=cand`, go to IDLE with no shift.
  - Else if `cnt==DEBOUNCE_CYCLES-1`, perform the shift, pulse `key_ack`, and go to HELD.
  - Else `cnt<=cnt+1`.
- Shift: `minutes<=sec_tens`, `sec_tens<=sec_ones`, `sec_ones<=cand`. The old `minutes` value is discarded.
- No range check on `sec_tens`: a value such as 9 may appear there. Normalisation belongs to the cook-timer.
- HELD: if `!valid`, set `cnt<=1` and go to RELEASE_WAIT. Otherwise stay in HELD. A change of `D` while held is ignored.
- RELEASE_WAIT:
  - If `valid`, go back to HELD (release bounce).
  - Else if `cnt==DEBOUNCE_CYCLES-1`, go to IDLE.
  - Else `cnt<=cnt+1`.
- `enable` affects only IDLE and PRESS_WAIT. Dropping it in HELD or RELEASE_WAIT does not abort release tracking.
- `clear` has priority over everything else. It zeros all three digits, forces the FSM to IDLE, and suppresses `key_ack`.
  - A key still held after `clear` must be released and re-pressed before it is accepted again. To guarantee this, `clear` in HELD or RELEASE_WAIT sends the FSM to RELEASE_WAIT with `cnt<=1` instead of IDLE.
- Codes 10..15 with `valid` high in IDLE are ignored: the FSM stays in IDLE.
- `time_nonzero` is registered from the next-state digit values, so it updates in the same cycle as the digits.

## Timing
- Reset values: all digits 0, `key_ack`=0, `time_nonzero`=0, FSM in IDLE, `cnt`=0, `cand`=0.
- Press latency: `valid` with a stable `D` must be sampled high on `DEBOUNCE_CYCLES` consecutive rising edges. The digits and `key_ack` update on the `DEBOUNCE_CYCLES`-th of those edges.
- `key_ack` is high for exactly one cycle per accepted key.
- Release: `valid` must be sampled low on `DEBOUNCE_CYCLES` consecutive edges before a new press can start. The earliest next acceptance is therefore `2*DEBOUNCE_CYCLES` edges after the release begins.
- A glitch shorter than `DEBOUNCE_CYCLES` samples in PRESS_WAIT causes no shift.
- Reset asserted mid-operation (any state) returns everything to reset values asynchronously. No pulse is produced on deassertion.

## Test plan
- Reset, then key 3 (`valid=1`, `D=3`) held for 10 cycles with `DEBOUNCE_CYCLES=4` -> `sec_ones=3` and `key_ack` high on the 4th edge only, `time_nonzero=1`, other digits 0.
- Keys 1, 3, 0 each pressed 6 cycles with 6-cycle gaps -> digits 1:3 0. A fourth key 5 -> 3:0 5 (the minutes digit 1 is discarded); exactly 4 `key_ack` pulses in total.
- `valid` high for 2 cycles, then `D` changing 4->7 mid-debounce, then a 3-cycle release bounce while held -> no shift from the glitch or the code change, and a single accept overall.
- `D=12` with `valid` held 10 cycles -> digits unchanged, no `key_ack`. `enable=0` with key 8 held -> no shift.
- `clear` asserted on the same edge a press would be accepted -> all digits 0, no `key_ack`. A key held through `clear` -> no accept until it is released and re-pressed.
- `reset` pulsed during PRESS_WAIT and during HELD with digits at 2:4 5 -> all outputs 0 immediately, and the next full press loads only `sec_ones`.
